// File: rtl/i2c_slave_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | i2c_slave_pkg : shared constants for the I2C register-bus slave   |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package i2c_slave_pkg;

   localparam int BIT_CNT_W = 3;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   localparam int STATE_W = 4;
   localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
   localparam logic [STATE_W-1:0] ST_DEV_ADDR = 4'd1;
   localparam logic [STATE_W-1:0] ST_DEV_ACK  = 4'd2;
   localparam logic [STATE_W-1:0] ST_REG_ADDR = 4'd3;
   localparam logic [STATE_W-1:0] ST_REG_ACK  = 4'd4;
   localparam logic [STATE_W-1:0] ST_WR_DATA  = 4'd5;
   localparam logic [STATE_W-1:0] ST_WR_ACK   = 4'd6;
   localparam logic [STATE_W-1:0] ST_RD_LOAD  = 4'd7;
   localparam logic [STATE_W-1:0] ST_RD_DATA  = 4'd8;
   localparam logic [STATE_W-1:0] ST_RD_ACK   = 4'd9;
   localparam logic [STATE_W-1:0] ST_SKIP     = 4'd10;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | i2c_line_filter : SCL/SDA synchroniser, glitch filter, edge and   |
// | START/STOP detection. Rev 1.0                                     |
// +-------------------------------------------------------------------+
module i2c_line_filter #(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_raw,
   input  logic sda_raw,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [1:0]          scl_sync, sda_sync;
   logic [FILT_LEN-1:0] scl_hist, sda_hist;
   logic                scl_flt, sda_flt, scl_flt_d, sda_flt_d;

   // Idle bus is high, so everything resets to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync  <= '1;
         sda_sync  <= '1;
         scl_hist  <= '1;
         sda_hist  <= '1;
         scl_flt   <= 1'b1;
         sda_flt   <= 1'b1;
         scl_flt_d <= 1'b1;
         sda_flt_d <= 1'b1;
         scl_rise  <= 1'b0;
         scl_fall  <= 1'b0;
         start_det <= 1'b0;
         stop_det  <= 1'b0;
      end else begin
         scl_sync  <= {scl_sync[0], scl_raw};
         sda_sync  <= {sda_sync[0], sda_raw};
         scl_hist  <= (scl_hist << 1) | FILT_LEN'(scl_sync[1]);
         sda_hist  <= (sda_hist << 1) | FILT_LEN'(sda_sync[1]);
         if (&scl_hist)       scl_flt <= 1'b1;
         else if (~|scl_hist) scl_flt <= 1'b0;
         if (&sda_hist)       sda_flt <= 1'b1;
         else if (~|sda_hist) sda_flt <= 1'b0;
         scl_flt_d <= scl_flt;
         sda_flt_d <= sda_flt;
         scl_rise  <= scl_flt & ~scl_flt_d;
         scl_fall  <= ~scl_flt & scl_flt_d;
         start_det <= scl_flt & scl_flt_d & sda_flt_d & ~sda_flt;
         stop_det  <= scl_flt & scl_flt_d & ~sda_flt_d & sda_flt;
      end
   end

   // Delayed level lines up with the registered edge pulses.
   assign sda = sda_flt_d;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_regbus.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | i2c_slave_regbus : I2C slave bridging to a word-wide register bus |
// | with auto-increment, repeated START and read prefetch. Rev 1.0    |
// +-------------------------------------------------------------------+
module i2c_slave_regbus
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] I2C_ADR    = 7'h27,
   parameter int         ADDR_W     = 8,
   parameter int         DATA_BYTES = 4,
   parameter int         FILT_LEN   = 3,
   parameter int         RD_LATENCY = 1
) (
   input  logic                    sys_clk_i,
   input  logic                    rst_n_i,
   input  logic                    scl_i,
   input  logic                    sda_i,
   output logic                    sda_oe_o,
   output logic                    ram_wr_en_o,
   output logic [ADDR_W-1:0]       ram_wr_addr_o,
   output logic [8*DATA_BYTES-1:0] ram_wr_data_o,
   output logic                    ram_rd_en_o,
   output logic [ADDR_W-1:0]       ram_rd_addr_o,
   input  logic [8*DATA_BYTES-1:0] ram_rd_data_i,
   output logic                    busy_o
);

   localparam int DATA_W = 8 * DATA_BYTES;
   localparam int BC_W   = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
   localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(DATA_BYTES - 1);

   logic                 sda, scl_rise, scl_fall, start_det, stop_det;
   logic [STATE_W-1:0]   state;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic                 byte_done;
   logic [7:0]           shift;
   logic [BC_W-1:0]      byte_cnt;
   logic [ADDR_W-1:0]    ptr;
   logic [DATA_W-1:0]    wr_word, rd_word;
   logic [RD_LATENCY-1:0] rd_pipe;
   logic                 rw;
   logic [7:0]           cur_byte;

   i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_filter (
      .clk       (sys_clk_i),
      .rst_n     (rst_n_i),
      .scl_raw   (scl_i),
      .sda_raw   (sda_i),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign cur_byte = rd_word[8*byte_cnt +: 8];

   always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state         <= ST_IDLE;
         bit_cnt       <= '0;
         byte_done     <= 1'b0;
         shift         <= '0;
         byte_cnt      <= '0;
         ptr           <= '0;
         wr_word       <= '0;
         rd_word       <= '0;
         rd_pipe       <= '0;
         rw            <= 1'b0;
         sda_oe_o      <= 1'b0;
         ram_wr_en_o   <= 1'b0;
         ram_wr_addr_o <= '0;
         ram_wr_data_o <= '0;
         ram_rd_en_o   <= 1'b0;
         ram_rd_addr_o <= '0;
         busy_o        <= 1'b0;
      end else begin
         ram_wr_en_o <= 1'b0;
         ram_rd_en_o <= 1'b0;
         rd_pipe     <= (rd_pipe << 1) | RD_LATENCY'(ram_rd_en_o);
         if (rd_pipe[RD_LATENCY-1]) rd_word <= ram_rd_data_i;

         if (start_det) begin
            state     <= ST_DEV_ADDR;
            bit_cnt   <= 3'd7;
            byte_done <= 1'b0;
            byte_cnt  <= '0;
            wr_word   <= '0;
            sda_oe_o  <= 1'b0;
         end else if (stop_det) begin
            state     <= ST_IDLE;
            byte_done <= 1'b0;
            byte_cnt  <= '0;
            wr_word   <= '0;
            sda_oe_o  <= 1'b0;
            busy_o    <= 1'b0;
         end else begin
            case (state)
               ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
                  if (scl_rise) begin
                     shift     <= {shift[6:0], sda};
                     bit_cnt   <= bit_cnt - 1'b1;
                     byte_done <= (bit_cnt == '0);
                  end else if (scl_fall && byte_done) begin
                     byte_done <= 1'b0;
                     if (state == ST_DEV_ADDR) begin
                        if (shift[7:1] == I2C_ADR) begin
                           sda_oe_o <= 1'b1;
                           busy_o   <= 1'b1;
                           rw       <= shift[0];
                           state    <= ST_DEV_ACK;
                        end else begin
                           state <= ST_SKIP;
                        end
                     end else if (state == ST_REG_ADDR) begin
                        ptr      <= shift[ADDR_W-1:0];
                        byte_cnt <= '0;
                        sda_oe_o <= 1'b1;
                        state    <= ST_REG_ACK;
                     end else begin
                        wr_word[8*byte_cnt +: 8] <= shift;
                        sda_oe_o <= 1'b1;
                        state    <= ST_WR_ACK;
                     end
                  end
               end
               ST_DEV_ACK: begin
                  // Reads fetch on the ACK rise so the word is ready at its fall.
                  if (scl_rise && rw) begin
                     ram_rd_en_o   <= 1'b1;
                     ram_rd_addr_o <= ptr;
                     byte_cnt      <= '0;
                     state         <= ST_RD_LOAD;
                  end else if (scl_fall) begin
                     sda_oe_o <= 1'b0;
                     bit_cnt  <= 3'd7;
                     state    <= ST_REG_ADDR;
                  end
               end
               ST_REG_ACK: begin
                  if (scl_fall) begin
                     sda_oe_o <= 1'b0;
                     bit_cnt  <= 3'd7;
                     state    <= ST_WR_DATA;
                  end
               end
               ST_WR_ACK: begin
                  if (scl_rise) begin
                     if (byte_cnt == LAST_BYTE) begin
                        ram_wr_en_o   <= 1'b1;
                        ram_wr_addr_o <= ptr;
                        ram_wr_data_o <= wr_word;
                        ptr           <= ptr + ADDR_W'(1);
                        byte_cnt      <= '0;
                     end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                     end
                  end else if (scl_fall) begin
                     sda_oe_o <= 1'b0;
                     bit_cnt  <= 3'd7;
                     state    <= ST_WR_DATA;
                  end
               end
               ST_RD_LOAD: begin
                  if (scl_fall) begin
                     sda_oe_o  <= ~cur_byte[7];
                     bit_cnt   <= 3'd6;
                     byte_done <= 1'b0;
                     state     <= ST_RD_DATA;
                  end
               end
               ST_RD_DATA: begin
                  if (scl_fall) begin
                     if (byte_done) begin
                        sda_oe_o  <= 1'b0;
                        byte_done <= 1'b0;
                        state     <= ST_RD_ACK;
                     end else begin
                        sda_oe_o  <= ~cur_byte[bit_cnt];
                        bit_cnt   <= bit_cnt - 1'b1;
                        byte_done <= (bit_cnt == '0);
                     end
                  end
               end
               ST_RD_ACK: begin
                  if (scl_rise) begin
                     if (sda == I2C_NACK) begin
                        state <= ST_SKIP;
                     end else begin
                        state <= ST_RD_LOAD;
                        if (byte_cnt == LAST_BYTE) begin
                           ptr           <= ptr + ADDR_W'(1);
                           ram_rd_en_o   <= 1'b1;
                           ram_rd_addr_o <= ptr + ADDR_W'(1);
                           byte_cnt      <= '0;
                        end else begin
                           byte_cnt <= byte_cnt + 1'b1;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regbus.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_i2c_slave_regbus : directed bench with write/read scoreboards  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_i2c_slave_regbus;
   import i2c_slave_pkg::*;

   localparam int Q = 15;

   logic        clk = 1'b0;
   logic        rst_n, scl_m, sda_m;
   logic        sda_oe, wr_en, rd_en, busy;
   logic [7:0]  wr_addr, rd_addr;
   logic [31:0] wr_data, rd_data;
   wire         sda_bus = sda_m & ~sda_oe;

   logic [31:0] mem [0:255];
   logic [39:0] exp_wr [$];
   logic [7:0]  exp_rd [$];
   int          checks = 0, errors = 0;
   bit          oe_seen, busy_seen;

   always #5 clk = ~clk;

   i2c_slave_regbus dut (
      .sys_clk_i     (clk),
      .rst_n_i       (rst_n),
      .scl_i         (scl_m),
      .sda_i         (sda_bus),
      .sda_oe_o      (sda_oe),
      .ram_wr_en_o   (wr_en),
      .ram_wr_addr_o (wr_addr),
      .ram_wr_data_o (wr_data),
      .ram_rd_en_o   (rd_en),
      .ram_rd_addr_o (rd_addr),
      .ram_rd_data_i (rd_data),
      .busy_o        (busy)
   );

   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sda_oe) oe_seen = 1'b1;
      if (busy)   busy_seen = 1'b1;
      if (wr_en && rd_en) chk("strobe_overlap", 40'd1, 40'd0);
      if (wr_en) begin
         if (exp_wr.size() == 0) chk("wr_unexpected", {wr_addr, wr_data}, 40'hx);
         else chk("wr_strobe", {wr_addr, wr_data}, exp_wr.pop_front());
      end
      if (rd_en) begin
         if (exp_rd.size() == 0) chk("rd_unexpected", {32'd0, rd_addr}, 40'hx);
         else chk("rd_strobe", {32'd0, rd_addr}, {32'd0, exp_rd.pop_front()});
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; cyc(Q);
      scl_m = 1'b1; cyc(Q);
      sda_m = 1'b0; cyc(Q);
      scl_m = 1'b0; cyc(4);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; cyc(Q);
      scl_m = 1'b1; cyc(Q);
      sda_m = 1'b1; cyc(Q);
   endtask

   task automatic wbit(input logic b);
      sda_m = b;    cyc(Q);
      scl_m = 1'b1; cyc(Q);
      scl_m = 1'b0; cyc(4);
   endtask

   task automatic rbit(output logic b);
      sda_m = 1'b1; cyc(Q);
      scl_m = 1'b1; cyc(Q/2);
      b = sda_bus;  cyc(Q - Q/2);
      scl_m = 1'b0; cyc(4);
   endtask

   task automatic wbyte(input logic [7:0] b, input logic exp_ack, input string tag);
      logic a;
      for (int i = 7; i >= 0; i--) wbit(b[i]);
      rbit(a);
      chk(tag, {39'd0, a}, {39'd0, exp_ack});
   endtask

   task automatic rbyte(input logic [7:0] exp, input logic ack, input string tag);
      logic [7:0] v;
      for (int i = 7; i >= 0; i--) rbit(v[i]);
      wbit(ack);
      chk(tag, {32'd0, v}, {32'd0, exp});
   endtask

   task automatic write_word_seq(input logic [7:0] reg_adr, input logic [31:0] w, input string tag);
      i2c_start();
      wbyte(8'h4E, I2C_ACK, {tag, "_dev"});
      chk({tag, "_busy"}, {39'd0, busy}, 40'd1);
      wbyte(reg_adr, I2C_ACK, {tag, "_reg"});
      for (int i = 0; i < 4; i++) wbyte(w[8*i +: 8], I2C_ACK, {tag, "_data"});
      i2c_stop();
      cyc(10);
      chk({tag, "_busy_end"}, {39'd0, busy}, 40'd0);
   endtask

   initial begin
      logic [7:0]  rd_bytes [8];
      logic [31:0] v;
      rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h20] = 32'hDDCCBBAA;
      mem[8'h21] = 32'h87654321;
      rd_data = 32'h0;
      cyc(5);
      chk("reset_ctl", {36'd0, sda_oe, wr_en, rd_en, busy}, 40'd0);
      chk("reset_wr", {wr_addr, wr_data}, 40'd0);
      chk("reset_rd_addr", {32'd0, rd_addr}, 40'd0);
      rst_n = 1'b1;
      cyc(10);

      // single word write
      exp_wr.push_back({8'h10, 32'h44332211});
      write_word_seq(8'h10, 32'h44332211, "t1");

      // two-word burst wrapping the pointer
      exp_wr.push_back({8'hFF, 32'h04030201});
      exp_wr.push_back({8'h00, 32'h08070605});
      i2c_start();
      wbyte(8'h4E, I2C_ACK, "t2_dev");
      wbyte(8'hFF, I2C_ACK, "t2_reg");
      for (int i = 1; i <= 8; i++) wbyte(8'(i), I2C_ACK, "t2_data");
      i2c_stop();
      chk("t2_mem_wrap", {8'd0, mem[8'h00]}, {8'd0, 32'h08070605});

      // combined read with repeated START
      exp_rd.push_back(8'h20);
      exp_rd.push_back(8'h21);
      rd_bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h21, 8'h43, 8'h65, 8'h87};
      i2c_start();
      wbyte(8'h4E, I2C_ACK, "t3_dev");
      wbyte(8'h20, I2C_ACK, "t3_reg");
      i2c_start();
      wbyte(8'h4F, I2C_ACK, "t3_devrd");
      for (int i = 0; i < 8; i++) rbyte(rd_bytes[i], (i == 7) ? I2C_NACK : I2C_ACK, "t3_rdata");
      i2c_stop();

      // foreign address: slave must stay silent
      cyc(10);
      oe_seen = 1'b0; busy_seen = 1'b0;
      i2c_start();
      wbyte(8'hA0, I2C_NACK, "t4_dev");
      for (int i = 0; i < 3; i++) wbyte(8'h5A, I2C_NACK, "t4_data");
      i2c_stop();
      chk("t4_oe_seen", {39'd0, oe_seen}, 40'd0);
      chk("t4_busy_seen", {39'd0, busy_seen}, 40'd0);

      // partial word discarded, then a full write
      i2c_start();
      wbyte(8'h4E, I2C_ACK, "t5_dev");
      wbyte(8'h30, I2C_ACK, "t5_reg");
      wbyte(8'hAA, I2C_ACK, "t5_data");
      wbyte(8'hBB, I2C_ACK, "t5_data");
      i2c_stop();
      exp_wr.push_back({8'h10, 32'h44332211});
      write_word_seq(8'h10, 32'h44332211, "t5b");

      // one-cycle SCL glitch inside a write
      v = 32'hDEADBEEF;
      exp_wr.push_back({8'h40, v});
      i2c_start();
      wbyte(8'h4E, I2C_ACK, "t6_dev");
      wbyte(8'h40, I2C_ACK, "t6_reg");
      scl_m = 1'b1; cyc(1);
      scl_m = 1'b0; cyc(Q);
      for (int i = 0; i < 4; i++) wbyte(v[8*i +: 8], I2C_ACK, "t6_data");
      i2c_stop();

      // reset asserted while the slave drives a read bit
      i2c_start();
      wbyte(8'h4E, I2C_ACK, "t7_dev");
      wbyte(8'h50, I2C_ACK, "t7_reg");
      i2c_stop();
      exp_rd.push_back(8'h50);
      i2c_start();
      wbyte(8'h4F, I2C_ACK, "t7_devrd");
      cyc(Q);
      chk("t7_pre_oe", {39'd0, sda_oe}, 40'd1);
      chk("t7_pre_state", {36'd0, dut.state}, {36'd0, ST_RD_DATA});
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_oe", {39'd0, sda_oe}, 40'd0);
      chk("t7_rst_state", {36'd0, dut.state}, {36'd0, ST_IDLE});
      chk("t7_rst_busy", {39'd0, busy}, 40'd0);
      scl_m = 1'b1; sda_m = 1'b1;
      cyc(5);
      rst_n = 1'b1;
      cyc(20);

      chk("wr_queue_empty", 40'(exp_wr.size()), 40'd0);
      chk("rd_queue_empty", 40'(exp_rd.size()), 40'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
